id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core: captures decoded operands, resolves RAW hazards by forwarding or stalling, and presents A/B/ALUOp/Shamt to the execute-stage ALU one cycle after decode. It also carries destination and control bits to EX/MEM. It is the only stall/bubble source between decode and execute.

## Interface
Parameters:
- DW, 32, datapath width (`DP_WIDTH`)
- OPW, 4, ALU opcode width (`ALUOP_WIDTH`)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs_addr / id_rt_addr  in  5  source register numbers
- id_rs_data / id_rt_data  in  DW  register-file read data (file is write-through)
- id_imm  in  16  instruction immediate
- id_imm_sel  in  2  B source: 0 rt, 1 sign-ext imm, 2 zero-ext imm, 3 imm<<16
- id_aluop  in  OPW  ALU opcode, passed through opaque
- id_shamt  in  5  shift amount
- id_rd_addr  in  5  destination register
- id_reg_write / id_mem_read / id_mem_write  in  1  control bits
- flush  in  1  kill the instruction entering EX
- mem_stall  in  1  downstream hold request
- exm_rd_addr  in  5; exm_reg_write  in  1; exm_result  in  DW  EX/MEM forward source
- wb_rd_addr  in  5; wb_reg_write  in  1; wb_data  in  DW  MEM/WB forward source
- ex_valid  out  1  EX slot valid
- ex_a / ex_b  out  DW  ALU operands
- ex_store_data  out  DW  forwarded rt, for stores
- ex_aluop  out  OPW; ex_shamt  out  5
- ex_rd_addr  out  5; ex_reg_write / ex_mem_read / ex_mem_write  out  1  (all gated by ex_valid)
- id_stall  out  1  hold PC and IF/ID

## Operation
- State register holds valid, rs/rt addr+data, ext-imm, imm_sel, aluop, shamt, rd, control bits.
- Per edge, priority: rst_n=0 → all state 0; mem_stall=1 → hold (see refresh); load-use hazard or flush → bubble (valid=0, controls 0); else capture ID fields, valid=id_valid.
- Hold refresh: while held, stored rs/rt data are overwritten with current forwarded values, so a WB write retiring during the hold is not lost.
- Forwarding (combinational, on EX side): per operand, if exm_reg_write & exm_rd_addr==addr & addr!=0 → exm_result; else if wb_reg_write & wb_rd_addr==addr & addr!=0 → wb_data; else stored data. EX/MEM has priority.
- ex_a = fwd(rs); ex_store_data = fwd(rt); ex_b = fwd(rt) if imm_sel=0, else the stored extended immediate (formed at capture).
- Load-use hazard: ex_valid & ex_mem_read & ex_rd_addr!=0 & ex_rd_addr∈{id_rs_addr,id_rt_addr} & id_valid. Both sources are compared, conservatively.
- id_stall = hazard | mem_stall.
- Flush during mem_stall: no capture, so no effect on this stage.

## Timing
- Latency: ID fields appear on ex_* exactly 1 cycle after the capturing edge.
- ex_a/ex_b/ex_store_data are combinational from state and forward inputs in the same cycle.
- Reset: every output 0; ex_valid=0 on the first cycle after rst_n sampled low.
- Load-use inserts exactly one bubble; id_stall is high for that one cycle (absent mem_stall).
- Reset mid-hold: reset wins and state clears.

## Configuration
- ID_EX_FWD_EN defined: forwarding as above.
- ID_EX_FWD_EN undefined: no forward muxes (ex_a/ex_b use stored data).
  - Hazard becomes any nonzero id_rs/rt match with a valid reg-writing EX slot or with exm_rd_addr/exm_reg_write. The stage bubbles until the match clears.
  - Hold refresh uses WB match only.

## Structure
- cpu_para.v holds DP_WIDTH, ALUOP_WIDTH, AluOp_* encodings, and new ImmSel_Reg/Sext/Zext/Lui constants.
- One sub-module, fwd_sel: a 2-source priority forward mux with the zero-register check, instantiated twice (rs, rt).

## Test plan
- add r3,r1,r2 with r1=5, r2=7 from the file, no hazards → next cycle ex_a=5, ex_b=7, ex_valid=1.
- EX/MEM writes r1=0x10 and WB writes r1=0x20 in the same cycle → ex_a=0x10. With rd=r0 on both → stored value is used.
- lw r4 in EX, ID reads r4 → id_stall=1 one cycle, one bubble (ex_valid=0), then consumer enters. Without ID_EX_FWD_EN: additional bubbles until exm clears.
- mem_stall=1 for 3 cycles while WB retires r2=0x99 used by the held instruction → after release, ex_b=0x99.
- ori imm 0xFFFF → ex_b=0x0000FFFF. addi imm 0xFFFF → ex_b=0xFFFFFFFF. lui 0x1234 → ex_b=0x12340000.
- flush=1 with valid ID → ex_valid=0. rst_n=0 mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, immediate-select encoding, ALU opcode constants and the register
// match helper for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int DP_WIDTH    = 32;
    localparam int ALUOP_WIDTH = 4;

    // B-operand source; everything except IMM_SEL_REG is extended at capture time
    typedef enum logic [1:0] {
        IMM_SEL_REG  = 2'd0,
        IMM_SEL_SEXT = 2'd1,
        IMM_SEL_ZEXT = 2'd2,
        IMM_SEL_LUI  = 2'd3
    } imm_sel_e;

    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD = 4'd0;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB = 4'd1;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_AND = 4'd2;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_OR  = 4'd3;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_XOR = 4'd4;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_NOR = 4'd5;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLT = 4'd6;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLL = 4'd7;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRL = 4'd8;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRA = 4'd9;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_LUI = 4'd10;

    // A write to r0 never matches: r0 is hardwired to zero.
    function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] src);
        return we && (rd != 5'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between the surrounding pipeline (master) and the ID/EX stage (slave).
interface id_ex_stage_if #(
    parameter int DW  = 32,
    parameter int OPW = 4
);
    // Handshake: id_valid marks a real instruction in decode; the stage accepts it on
    // a rising edge only while id_stall is low, otherwise decode must hold all id_* fields.
    logic          id_valid;
    logic [4:0]    id_rs_addr;
    logic [4:0]    id_rt_addr;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [15:0]   id_imm;
    logic [1:0]    id_imm_sel;
    logic [OPW-1:0] id_aluop;
    logic [4:0]    id_shamt;
    logic [4:0]    id_rd_addr;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          flush;
    logic          mem_stall;
    logic [4:0]    exm_rd_addr;
    logic          exm_reg_write;
    logic [DW-1:0] exm_result;
    logic [4:0]    wb_rd_addr;
    logic          wb_reg_write;
    logic [DW-1:0] wb_data;

    logic          ex_valid;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [DW-1:0] ex_store_data;
    logic [OPW-1:0] ex_aluop;
    logic [4:0]    ex_shamt;
    logic [4:0]    ex_rd_addr;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          id_stall;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm, id_imm_sel,
               id_aluop, id_shamt, id_rd_addr, id_reg_write, id_mem_read, id_mem_write,
               flush, mem_stall, exm_rd_addr, exm_reg_write, exm_result,
               wb_rd_addr, wb_reg_write, wb_data,
        input  ex_valid, ex_a, ex_b, ex_store_data, ex_aluop, ex_shamt, ex_rd_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, id_stall
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm, id_imm_sel,
               id_aluop, id_shamt, id_rd_addr, id_reg_write, id_mem_read, id_mem_write,
               flush, mem_stall, exm_rd_addr, exm_reg_write, exm_result,
               wb_rd_addr, wb_reg_write, wb_data,
        output ex_valid, ex_a, ex_b, ex_store_data, ex_aluop, ex_shamt, ex_rd_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, id_stall
    );

endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Two-source priority forward mux: EX/MEM beats MEM/WB beats the stored operand;
// r0 is never forwarded.
module id_ex_stage_fwd_sel
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DP_WIDTH
) (
    input  logic [4:0]    src_addr,
    input  logic [DW-1:0] src_data,
    input  logic          exm_we,
    input  logic [4:0]    exm_rd,
    input  logic [DW-1:0] exm_data,
    input  logic          wb_we,
    input  logic [4:0]    wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] fwd_data
);

    always_comb begin
        fwd_data = src_data;
        if (reg_match(exm_we, exm_rd, src_addr)) begin
            fwd_data = exm_data;
        end else if (reg_match(wb_we, wb_rd, src_addr)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW forwarding, load-use stall and bubble insertion.
// Define ID_EX_FWD_EN to enable EX-side forwarding; otherwise the stage stalls on every RAW match.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW  = DP_WIDTH,
    parameter int OPW = ALUOP_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic           valid;
        logic [4:0]     rs_addr;
        logic [4:0]     rt_addr;
        logic [DW-1:0]  rs_data;
        logic [DW-1:0]  rt_data;
        logic [DW-1:0]  ext_imm;
        imm_sel_e       imm_sel;
        logic [OPW-1:0] aluop;
        logic [4:0]     shamt;
        logic [4:0]     rd_addr;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
    } stage_t;

    stage_t        q;
    logic [DW-1:0] ext_imm_d;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;
    logic          exm_fwd_we;
    logic          rs_hit_ex;
    logic          rt_hit_ex;
    logic          hazard;

    always_comb begin
        ext_imm_d = '0;
        case (imm_sel_e'(bus.id_imm_sel))
            IMM_SEL_SEXT: ext_imm_d = {{(DW-16){bus.id_imm[15]}}, bus.id_imm};
            IMM_SEL_ZEXT: ext_imm_d = {{(DW-16){1'b0}}, bus.id_imm};
            IMM_SEL_LUI:  ext_imm_d = {bus.id_imm, {(DW-16){1'b0}}};
            default:      ext_imm_d = '0;
        endcase
    end

    // The same muxes feed both the EX operands and the hold refresh; without
    // forwarding the EX/MEM leg is disabled so only WB refreshes a held operand.
    id_ex_stage_fwd_sel #(.DW(DW)) u_fwd_rs (
        .src_addr (q.rs_addr),
        .src_data (q.rs_data),
        .exm_we   (exm_fwd_we),
        .exm_rd   (bus.exm_rd_addr),
        .exm_data (bus.exm_result),
        .wb_we    (bus.wb_reg_write),
        .wb_rd    (bus.wb_rd_addr),
        .wb_data  (bus.wb_data),
        .fwd_data (rs_fwd)
    );

    id_ex_stage_fwd_sel #(.DW(DW)) u_fwd_rt (
        .src_addr (q.rt_addr),
        .src_data (q.rt_data),
        .exm_we   (exm_fwd_we),
        .exm_rd   (bus.exm_rd_addr),
        .exm_data (bus.exm_result),
        .wb_we    (bus.wb_reg_write),
        .wb_rd    (bus.wb_rd_addr),
        .wb_data  (bus.wb_data),
        .fwd_data (rt_fwd)
    );

    assign rs_hit_ex = reg_match(1'b1, q.rd_addr, bus.id_rs_addr);
    assign rt_hit_ex = reg_match(1'b1, q.rd_addr, bus.id_rt_addr);

`ifdef ID_EX_FWD_EN
    assign exm_fwd_we        = bus.exm_reg_write;
    assign bus.ex_a          = rs_fwd;
    assign bus.ex_store_data = rt_fwd;
    assign bus.ex_b          = (q.imm_sel == IMM_SEL_REG) ? rt_fwd : q.ext_imm;
    // Only a load in EX cannot be forwarded in time; both sources compared conservatively.
    assign hazard = bus.id_valid && q.valid && q.mem_read && (rs_hit_ex || rt_hit_ex);
`else
    assign exm_fwd_we        = 1'b0;
    assign bus.ex_a          = q.rs_data;
    assign bus.ex_store_data = q.rt_data;
    assign bus.ex_b          = (q.imm_sel == IMM_SEL_REG) ? q.rt_data : q.ext_imm;
    // Any pending writer in EX or EX/MEM blocks decode until the write reaches the register file.
    assign hazard = bus.id_valid &&
                    ((q.valid && q.reg_write && (rs_hit_ex || rt_hit_ex)) ||
                     reg_match(bus.exm_reg_write, bus.exm_rd_addr, bus.id_rs_addr) ||
                     reg_match(bus.exm_reg_write, bus.exm_rd_addr, bus.id_rt_addr));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bus.mem_stall) begin
            q.rs_data <= rs_fwd;
            q.rt_data <= rt_fwd;
        end else if (hazard || bus.flush) begin
            q <= '0;
        end else begin
            q.valid     <= bus.id_valid;
            q.rs_addr   <= bus.id_rs_addr;
            q.rt_addr   <= bus.id_rt_addr;
            q.rs_data   <= bus.id_rs_data;
            q.rt_data   <= bus.id_rt_data;
            q.ext_imm   <= ext_imm_d;
            q.imm_sel   <= imm_sel_e'(bus.id_imm_sel);
            q.aluop     <= bus.id_aluop;
            q.shamt     <= bus.id_shamt;
            q.rd_addr   <= bus.id_rd_addr;
            q.reg_write <= bus.id_reg_write;
            q.mem_read  <= bus.id_mem_read;
            q.mem_write <= bus.id_mem_write;
        end
    end

    assign bus.ex_valid     = q.valid;
    assign bus.ex_aluop     = q.aluop;
    assign bus.ex_shamt     = q.shamt;
    assign bus.ex_rd_addr   = q.valid ? q.rd_addr : 5'd0;
    assign bus.ex_reg_write = q.valid & q.reg_write;
    assign bus.ex_mem_read  = q.valid & q.mem_read;
    assign bus.ex_mem_write = q.valid & q.mem_write;
    assign bus.id_stall     = hazard | bus.mem_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  id_ex_stage_if #(.DW(32), .OPW(4)) bus ();

  id_ex_stage #(.DW(32), .OPW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus.id_valid = 1'b0; bus.id_rs_addr = 5'd0; bus.id_rt_addr = 5'd0;
    bus.id_rs_data = 32'd0; bus.id_rt_data = 32'd0; bus.id_imm = 16'd0; bus.id_imm_sel = 2'd0;
    bus.id_aluop = 4'd0; bus.id_shamt = 5'd0; bus.id_rd_addr = 5'd0;
    bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
    bus.flush = 1'b0; bus.mem_stall = 1'b0;
    bus.exm_rd_addr = 5'd0; bus.exm_reg_write = 1'b0; bus.exm_result = 32'd0;
    bus.wb_rd_addr = 5'd0; bus.wb_reg_write = 1'b0; bus.wb_data = 32'd0;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [31:0] rs_d, input logic [4:0] rt,
                             input logic [31:0] rt_d, input logic [15:0] imm, input logic [1:0] sel,
                             input logic [3:0] op, input logic [4:0] rd, input logic rw, input logic mr);
    bus.id_valid = 1'b1; bus.id_rs_addr = rs; bus.id_rs_data = rs_d;
    bus.id_rt_addr = rt; bus.id_rt_data = rt_d; bus.id_imm = imm; bus.id_imm_sel = sel;
    bus.id_aluop = op; bus.id_shamt = 5'd0; bus.id_rd_addr = rd;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = 1'b0;
  endtask

  task automatic test_reset;
    drive_idle();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %h exp 0", bus.ex_valid); end
    n_checks++; if (bus.ex_a !== 32'd0) begin n_errors++; $display("FAIL reset_a: got %h exp 0", bus.ex_a); end
    n_checks++; if (bus.ex_b !== 32'd0) begin n_errors++; $display("FAIL reset_b: got %h exp 0", bus.ex_b); end
    n_checks++; if (bus.id_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %h exp 0", bus.id_stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add;
    drive_idle();
    drive_instr(5'd1, 32'd5, 5'd2, 32'd7, 16'd0, 2'd0, 4'd0, 5'd3, 1'b1, 1'b0);
    tick();
    drive_idle();
    #1;
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_errors++; $display("FAIL add_valid: got %h exp 1", bus.ex_valid); end
    n_checks++; if (bus.ex_a !== 32'd5) begin n_errors++; $display("FAIL add_a: got %h exp 5", bus.ex_a); end
    n_checks++; if (bus.ex_b !== 32'd7) begin n_errors++; $display("FAIL add_b: got %h exp 7", bus.ex_b); end
    n_checks++; if (bus.ex_rd_addr !== 5'd3) begin n_errors++; $display("FAIL add_rd: got %h exp 3", bus.ex_rd_addr); end
    n_checks++; if (bus.ex_reg_write !== 1'b1) begin n_errors++; $display("FAIL add_rw: got %h exp 1", bus.ex_reg_write); end
  endtask

  task automatic test_forward;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    drive_idle();
    drive_instr(5'd1, 32'h1, 5'd2, 32'h2, 16'd0, 2'd0, 4'd1, 5'd9, 1'b1, 1'b0);
    tick();
    drive_idle();
    bus.exm_rd_addr = 5'd1; bus.exm_reg_write = 1'b1; bus.exm_result = 32'h10;
    bus.wb_rd_addr = 5'd1; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h20;
    #1;
`ifdef ID_EX_FWD_EN
    exp_a = 32'h10;
`else
    exp_a = 32'h1;
`endif
    n_checks++; if (bus.ex_a !== exp_a) begin n_errors++; $display("FAIL fwd_prio_a: got %h exp %h", bus.ex_a, exp_a); end
    bus.exm_rd_addr = 5'd0; bus.wb_rd_addr = 5'd0;
    #1;
    n_checks++; if (bus.ex_a !== 32'h1) begin n_errors++; $display("FAIL fwd_r0_a: got %h exp 1", bus.ex_a); end
    bus.exm_reg_write = 1'b0; bus.wb_rd_addr = 5'd2;
    #1;
`ifdef ID_EX_FWD_EN
    exp_b = 32'h20;
`else
    exp_b = 32'h2;
`endif
    n_checks++; if (bus.ex_b !== exp_b) begin n_errors++; $display("FAIL fwd_wb_b: got %h exp %h", bus.ex_b, exp_b); end
    n_checks++; if (bus.ex_store_data !== exp_b) begin n_errors++; $display("FAIL fwd_wb_st: got %h exp %h", bus.ex_store_data, exp_b); end
    drive_idle();
  endtask

  task automatic test_load_use;
    drive_idle();
    drive_instr(5'd5, 32'd100, 5'd0, 32'd0, 16'd8, 2'd1, 4'd0, 5'd4, 1'b1, 1'b1);
    tick();
    n_checks++; if (bus.ex_mem_read !== 1'b1) begin n_errors++; $display("FAIL lw_mr: got %h exp 1", bus.ex_mem_read); end
    n_checks++; if (bus.ex_b !== 32'd8) begin n_errors++; $display("FAIL lw_b: got %h exp 8", bus.ex_b); end
    drive_instr(5'd4, 32'd0, 5'd1, 32'd5, 16'd0, 2'd0, 4'd0, 5'd6, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.id_stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall: got %h exp 1", bus.id_stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_errors++; $display("FAIL lu_bubble: got %h exp 0", bus.ex_valid); end
    bus.exm_rd_addr = 5'd4; bus.exm_reg_write = 1'b1;
    #1;
`ifdef ID_EX_FWD_EN
    n_checks++; if (bus.id_stall !== 1'b0) begin n_errors++; $display("FAIL lu_release: got %h exp 0", bus.id_stall); end
    tick();
    bus.id_valid = 1'b0; bus.exm_rd_addr = 5'd0; bus.exm_reg_write = 1'b0;
    bus.wb_rd_addr = 5'd4; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h44;
    #1;
`else
    n_checks++; if (bus.id_stall !== 1'b1) begin n_errors++; $display("FAIL lu_exm_stall: got %h exp 1", bus.id_stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_errors++; $display("FAIL lu_bubble2: got %h exp 0", bus.ex_valid); end
    bus.exm_rd_addr = 5'd0; bus.exm_reg_write = 1'b0; bus.id_rs_data = 32'h44;
    bus.wb_rd_addr = 5'd4; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h44;
    #1;
    n_checks++; if (bus.id_stall !== 1'b0) begin n_errors++; $display("FAIL lu_release: got %h exp 0", bus.id_stall); end
    tick();
    bus.id_valid = 1'b0; bus.wb_reg_write = 1'b0;
    #1;
`endif
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_errors++; $display("FAIL lu_consumer_valid: got %h exp 1", bus.ex_valid); end
    n_checks++; if (bus.ex_rd_addr !== 5'd6) begin n_errors++; $display("FAIL lu_consumer_rd: got %h exp 6", bus.ex_rd_addr); end
    n_checks++; if (bus.ex_a !== 32'h44) begin n_errors++; $display("FAIL lu_consumer_a: got %h exp 44", bus.ex_a); end
    drive_idle();
  endtask

  task automatic test_mem_stall_refresh;
    drive_idle();
    drive_instr(5'd1, 32'd3, 5'd2, 32'd0, 16'd0, 2'd0, 4'd0, 5'd3, 1'b1, 1'b0);
    tick();
    drive_instr(5'd7, 32'd1, 5'd8, 32'd1, 16'd0, 2'd0, 4'd2, 5'd10, 1'b1, 1'b0);
    bus.mem_stall = 1'b1;
    bus.wb_rd_addr = 5'd2; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h99;
    #1;
    n_checks++; if (bus.id_stall !== 1'b1) begin n_errors++; $display("FAIL hold_stall: got %h exp 1", bus.id_stall); end
    tick();
    bus.wb_reg_write = 1'b0; bus.wb_data = 32'h0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_errors++; $display("FAIL hold_flush_ignored: got %h exp 1", bus.ex_valid); end
    tick();
    n_checks++; if (bus.ex_rd_addr !== 5'd3) begin n_errors++; $display("FAIL hold_rd: got %h exp 3", bus.ex_rd_addr); end
    bus.mem_stall = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    n_checks++; if (bus.ex_b !== 32'h99) begin n_errors++; $display("FAIL hold_refresh_b: got %h exp 99", bus.ex_b); end
    n_checks++; if (bus.ex_a !== 32'd3) begin n_errors++; $display("FAIL hold_a: got %h exp 3", bus.ex_a); end
    drive_idle();
  endtask

  task automatic test_imm_back_to_back;
    drive_idle();
    drive_instr(5'd0, 32'd0, 5'd0, 32'd0, 16'hFFFF, 2'd2, 4'd3, 5'd8, 1'b1, 1'b0);
    tick();
    n_checks++; if (bus.ex_b !== 32'h0000FFFF) begin n_errors++; $display("FAIL ori_b: got %h exp 0000ffff", bus.ex_b); end
    drive_instr(5'd0, 32'd0, 5'd0, 32'd0, 16'hFFFF, 2'd1, 4'd0, 5'd8, 1'b1, 1'b0);
    tick();
    n_checks++; if (bus.ex_b !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL addi_b: got %h exp ffffffff", bus.ex_b); end
    drive_instr(5'd0, 32'd0, 5'd0, 32'd0, 16'h1234, 2'd3, 4'd10, 5'd8, 1'b1, 1'b0);
    tick();
    n_checks++; if (bus.ex_b !== 32'h12340000) begin n_errors++; $display("FAIL lui_b: got %h exp 12340000", bus.ex_b); end
    n_checks++; if (bus.ex_aluop !== 4'd10) begin n_errors++; $display("FAIL lui_op: got %h exp a", bus.ex_aluop); end
    drive_idle();
  endtask

  task automatic test_flush;
    drive_idle();
    drive_instr(5'd1, 32'd5, 5'd2, 32'd7, 16'd0, 2'd0, 4'd0, 5'd11, 1'b1, 1'b0);
    bus.flush = 1'b1;
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %h exp 0", bus.ex_valid); end
    n_checks++; if (bus.ex_reg_write !== 1'b0) begin n_errors++; $display("FAIL flush_rw: got %h exp 0", bus.ex_reg_write); end
    bus.flush = 1'b0;
    tick();
    n_checks++; if (bus.ex_rd_addr !== 5'd11) begin n_errors++; $display("FAIL after_flush_rd: got %h exp b", bus.ex_rd_addr); end
  endtask

  task automatic test_reset_mid_hold;
    drive_instr(5'd1, 32'd5, 5'd2, 32'd7, 16'h0001, 2'd1, 4'd4, 5'd12, 1'b1, 1'b0);
    bus.mem_stall = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive_idle();
    #1;
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_valid: got %h exp 0", bus.ex_valid); end
    n_checks++; if (bus.ex_a !== 32'd0) begin n_errors++; $display("FAIL rst_mid_a: got %h exp 0", bus.ex_a); end
    n_checks++; if (bus.ex_b !== 32'd0) begin n_errors++; $display("FAIL rst_mid_b: got %h exp 0", bus.ex_b); end
    n_checks++; if (bus.ex_rd_addr !== 5'd0) begin n_errors++; $display("FAIL rst_mid_rd: got %h exp 0", bus.ex_rd_addr); end
    n_checks++; if (bus.ex_aluop !== 4'd0) begin n_errors++; $display("FAIL rst_mid_op: got %h exp 0", bus.ex_aluop); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_basic_add();
    test_forward();
    test_load_use();
    test_mem_stall_refresh();
    test_imm_back_to_back();
    test_flush();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
